// File: rtl/rram_xbar_seq_if.sv
// Bus between the RRAM crossbar sequencer and its controller.
//   start, mode, abort : operation request / select / cancel (controller -> sequencer)
//   wdata[15:0]        : 4x4 weight matrix, row r in wdata[4r+3:4r]
//   xin[3:0]           : compute input vector
//   Dwl/Dsl/Dbl[3:0]   : word-, source-, bit-line enables to the cell array
//   Dset               : 1 = SET-level bit-line drive, 0 = read-level drive
//   busy, sample, done : status, analog-sum-valid strobe, completion pulse
interface rram_xbar_seq_if;
  logic        start;
  logic        mode;
  logic        abort;
  logic [15:0] wdata;
  logic [3:0]  xin;
  logic [3:0]  Dwl;
  logic [3:0]  Dsl;
  logic [3:0]  Dbl;
  logic        Dset;
  logic        busy;
  logic        sample;
  logic        done;

  modport master (
    output start, mode, abort, wdata, xin,
    input  Dwl, Dsl, Dbl, Dset, busy, sample, done
  );

  modport slave (
    input  start, mode, abort, wdata, xin,
    output Dwl, Dsl, Dbl, Dset, busy, sample, done
  );
endinterface

// File: rtl/rram_xbar_seq.sv
// RRAM 4x4 crossbar sequencer.
// Program mode SETs the array one row at a time (pulse then all-zero gap per
// row); compute mode drives all word lines with the input vector on the bit
// lines, waits a settle time and strobes sample.
// Ports: clk, rst (async, active-high), bus (rram_xbar_seq_if.slave).
// Every output is a register loaded from the next-state decode, so the line
// drive for a state appears in the same cycle the state is entered.
module rram_xbar_seq #(
  parameter int PULSE_CYC  = 8,
  parameter int GAP_CYC    = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  rram_xbar_seq_if.slave  bus
);

  localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    PROG_PULSE,
    PROG_GAP,
    CMP_SETTLE,
    CMP_SAMPLE,
    DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [1:0]  row, row_n;
  logic [15:0] wlat, wlat_n;
  logic [3:0]  xlat, xlat_n;
  logic        mode_lat, mode_n;

  logic [3:0]  dwl_n, dsl_n, dbl_n;
  logic        dset_n, busy_n, sample_n, done_n;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 8'd1;
    row_n    = row;
    wlat_n   = wlat;
    xlat_n   = xlat;
    mode_n   = mode_lat;

    case (state)
      IDLE: begin
        cnt_n = '0;
        // start together with abort is treated as no request
        if (bus.start && !bus.abort) begin
          wlat_n  = bus.wdata;
          xlat_n  = bus.xin;
          mode_n  = bus.mode;
          row_n   = '0;
          state_n = bus.mode ? CMP_SETTLE : PROG_PULSE;
        end
      end
      PROG_PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_n   = '0;
          state_n = PROG_GAP;
        end
      end
      PROG_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (row == 2'd3) begin
            state_n = DONE;
          end else begin
            row_n   = row + 2'd1;
            state_n = PROG_PULSE;
          end
        end
      end
      CMP_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_n   = '0;
          state_n = CMP_SAMPLE;
        end
      end
      CMP_SAMPLE: begin
        cnt_n   = '0;
        state_n = DONE;
      end
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    // abort wins over every other transition, including the DONE exit
    if (state != IDLE && bus.abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      row_n   = '0;
    end

    // output decode from the state being entered
    dwl_n    = '0;
    dsl_n    = '0;
    dbl_n    = '0;
    dset_n   = 1'b0;
    busy_n   = (state_n != IDLE);
    sample_n = 1'b0;
    done_n   = 1'b0;
    case (state_n)
      PROG_PULSE: begin
        dwl_n  = 4'b0001 << row_n;
        dbl_n  = wlat_n[{row_n, 2'b00} +: 4];
        dset_n = 1'b1;
      end
      CMP_SETTLE: begin
        dwl_n = 4'hF;
        dbl_n = xlat_n;
      end
      CMP_SAMPLE: begin
        dwl_n    = 4'hF;
        dbl_n    = xlat_n;
        sample_n = 1'b1;
      end
      DONE: begin
        done_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      row        <= '0;
      wlat       <= '0;
      xlat       <= '0;
      mode_lat   <= 1'b0;
      bus.Dwl    <= '0;
      bus.Dsl    <= '0;
      bus.Dbl    <= '0;
      bus.Dset   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.sample <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      row        <= row_n;
      wlat       <= wlat_n;
      xlat       <= xlat_n;
      mode_lat   <= mode_n;
      bus.Dwl    <= dwl_n;
      bus.Dsl    <= dsl_n;
      bus.Dbl    <= dbl_n;
      bus.Dset   <= dset_n;
      bus.busy   <= busy_n;
      bus.sample <= sample_n;
      bus.done   <= done_n;
    end
  end

endmodule

// File: doc/rram_xbar_seq.md
RRAM_XBAR_SEQ -- requirements
Module: rram_xbar_seq

Interface
REQ-001 Parameter PULSE_CYC, default 8, legal range 1..255: SET-pulse width per row, in clocks.
REQ-002 Parameter GAP_CYC, default 1, legal range 1..255: all-zero gap after each row pulse, in clocks.
REQ-003 Parameter SETTLE_CYC, default 4, legal range 1..255: compute settle time before the sample strobe, in clocks.
REQ-004 clk  input  1  the block's one clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  request an operation; sampled only in IDLE.
REQ-007 mode  input  1  0 = program weights, 1 = compute; sampled with start.
REQ-008 abort  input  1  synchronous cancel of an operation in progress.
REQ-009 wdata  input  16  weight matrix; row r = wdata[4r+3:4r], bit c drives column c.
REQ-010 xin  input  4  compute input vector.
REQ-011 Dwl  output  4  word-line enables to the 4x4 RRAM cell array.
REQ-012 Dsl  output  4  source-line enables.
REQ-013 Dbl  output  4  bit-line enables.
REQ-014 Dset  output  1  1 = SET-level bit-line drive, 0 = read-level drive.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 sample  output  1  one-cycle strobe: the analog sum outputs are valid.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 All outputs shall be registered and driven from state and counter only.
- States: IDLE, PROG_PULSE, PROG_GAP, CMP_SETTLE, CMP_SAMPLE, DONE.
REQ-019 In IDLE, an edge with start=1 shall latch wdata, xin and mode.
- mode=0 -> PROG_PULSE, row index 0, cycle counter 0.
- mode=1 -> CMP_SETTLE, cycle counter 0.
REQ-020 In PROG_PULSE, the block shall drive the following for exactly PULSE_CYC cycles, then go to PROG_GAP:
- Dwl = one-hot(row); Dbl = latched row bits; Dsl = 0; Dset = 1.
REQ-021 In PROG_GAP, the block shall drive Dwl=Dbl=Dsl=0 and Dset=0 for exactly GAP_CYC cycles.
- Then row < 3 -> row+1 and back to PROG_PULSE.
- Row 3 -> DONE.
REQ-022 An all-zero weight row shall still receive its full pulse interval, with Dbl=0; rows are never skipped.
REQ-023 In CMP_SETTLE, the block shall drive the following for SETTLE_CYC cycles, then go to CMP_SAMPLE:
- Dwl = 4'hF; Dbl = latched xin; Dsl = 0; Dset = 0.
REQ-024 CMP_SAMPLE shall last one cycle with the same drive as CMP_SETTLE and sample=1, then go to DONE.
REQ-025 DONE shall last one cycle with done=1 and all line outputs 0, then go to IDLE.
REQ-026 start shall be ignored while busy=1; wdata and xin changes after latching shall have no effect.
REQ-027 abort=1 in any non-IDLE state shall move the block to IDLE on that edge.
- All line outputs are 0 from the next cycle.
- No done and no sample pulse.
- Abort takes priority over every other transition, including the DONE exit.
REQ-028 abort in IDLE shall have no effect; start and abort high together in IDLE shall leave the block in IDLE.
REQ-029 Dset shall never be 1 while Dwl has more than one bit set.
REQ-030 Dset shall never be 1 in a compute state.
REQ-031 Cycle counters shall be 8 bits, reload to 0 on each state entry, and never wrap within a state.

Reset
REQ-032 While rst=1, the block shall hold the following immediately and asynchronously:
- state IDLE; Dwl=Dsl=Dbl=0; Dset=0; busy=0; sample=0; done=0.
- Row and cycle counters 0; latched wdata, xin and mode cleared.
REQ-033 Reset asserted mid-operation shall abandon it with no done pulse.
- The first start after reset release shall be accepted normally.

Verification
REQ-034 Program, defaults, wdata=16'hA5C3, start at edge 0:
- Row 0 drives Dwl=0001, Dbl=0011, Dset=1 in cycles 1-8; gap in cycle 9.
- Rows 1/2/3 drive Dbl=1100/0101/1010.
- done=1 in cycle 37 only; busy high cycles 1-37.
REQ-035 Compute, defaults, xin=4'b1011:
- Dwl=1111, Dbl=1011, Dset=0 in cycles 1-5.
- sample=1 in cycle 5 only; done=1 in cycle 6.
REQ-036 Second start during a program run (cycle 12, mode=1) -> ignored; timing identical to REQ-034.
REQ-037 abort at cycle 20 of a program run -> outputs 0 from cycle 21, busy=0, no done; a following start is accepted.
REQ-038 rst asserted at cycle 3 of a compute run -> all outputs 0 immediately, no sample or done; PULSE_CYC=1 and GAP_CYC=1 program run -> done in cycle 9.
REQ-039 Assertion over all runs: Dset=1 implies $onehot(Dwl), and Dset=0 in every compute state.
